// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive back-end: register map, command and
// control field positions, the FIFO entry layout and the filter key builder.
package can_pkg;

    localparam int KEY_W  = 32;
    localparam int DATA_W = 64;
    localparam int FHW    = 3;
    localparam int ID_W   = 29;

    localparam logic [2:0] RXID   = 3'd0;
    localparam logic [2:0] RXSTAT = 3'd1;
    localparam logic [2:0] DATA0  = 3'd2;
    localparam logic [2:0] DATA1  = 3'd3;
    localparam logic [2:0] CMD    = 3'd4;
    localparam logic [2:0] CTRL   = 3'd5;
    localparam logic [2:0] FMATCH = 3'd6;
    localparam logic [2:0] FMASK  = 3'd7;

    localparam int CMD_POP    = 0;
    localparam int CMD_FLUSH  = 1;
    localparam int CMD_OVFCLR = 2;

    localparam int CTRL_FEN_LSB   = 0;
    localparam int CTRL_THR_LSB   = 8;
    localparam int CTRL_FSEL_LSB  = 16;
    localparam int CTRL_IRQEN_LSB = 24;

    typedef struct packed {
        logic              ext;
        logic              rtr;
        logic [ID_W-1:0]   id;
        logic [3:0]        dlc;
        logic [DATA_W-1:0] data;
        logic [FHW-1:0]    fhit;
    } can_entry_t;

    // Key layout shared by the acceptance filters and the RXID register.
    function automatic logic [KEY_W-1:0] can_key(input logic ext, input logic rtr,
                                                 input logic [ID_W-1:0] id);
        return {ext, rtr, 1'b0, id};
    endfunction

endpackage

// File: rtl/can_acc_filter.sv
// Mask/match acceptance filter bank: reports whether a frame key is accepted
// and which enabled filter (lowest index) matched it.
module can_acc_filter
    import can_pkg::*;
#(
    parameter int NFILT = 4
) (
    input  logic [KEY_W-1:0]             i_key,
    input  logic [NFILT-1:0]             i_fen,
    input  logic [NFILT-1:0][KEY_W-1:0]  i_match,
    input  logic [NFILT-1:0][KEY_W-1:0]  i_mask,
    output logic                         o_accept,
    output logic [FHW-1:0]               o_fhit
);

    logic [NFILT-1:0] w_hit;

    // Per-filter compare: only bits with mask=1 must agree.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NFILT; i++) begin
            w_hit[i] = i_fen[i] & (((i_key ^ i_match[i]) & i_mask[i]) == '0);
        end
    end

    // Scan from the top down so the lowest hitting index wins.
    always_comb begin
        o_fhit = '0;
        for (int i = NFILT - 1; i >= 0; i--) begin
            o_fhit = w_hit[i] ? FHW'(i) : o_fhit;
        end
    end

    assign o_accept = (i_fen == '0) | (|w_hit);

endmodule

// File: rtl/can_rx_filter_fifo.sv
// CAN receive back-end: filters decoded frames, queues accepted ones in an RX
// FIFO and exposes head, status, control and filter registers on the bus.
module can_rx_filter_fifo
    import can_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NFILT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [2:0]        rs,
    input  logic [31:0]       d,
    output logic [31:0]       q,
    input  logic              frm_valid,
    input  logic              frm_ext,
    input  logic              frm_rtr,
    input  logic [ID_W-1:0]   frm_id,
    input  logic [3:0]        frm_dlc,
    input  logic [DATA_W-1:0] frm_data,
    output logic              irq_rx,
    output logic              irq_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = (NFILT > 1) ? $clog2(NFILT) : 1;

    can_entry_t                 r_mem [DEPTH];
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_ovf;
    logic [NFILT-1:0]           r_fen;
    logic [4:0]                 r_thresh;
    logic [2:0]                 r_fsel;
    logic [1:0]                 r_irqen;
    logic [NFILT-1:0][KEY_W-1:0] r_match;
    logic [NFILT-1:0][KEY_W-1:0] r_mask;
    logic                       r_irq_rx;
    logic                       r_irq_ovf;

    logic [KEY_W-1:0] w_key;
    logic             w_accept;
    logic [FHW-1:0]   w_fhit;
    logic             w_full;
    logic             w_empty;
    logic             w_cmd_wr;
    logic             w_pop;
    logic             w_flush;
    logic             w_ovf_clr;
    logic             w_push_req;
    logic             w_push;
    logic             w_ovf_evt;
    logic             w_fsel_ok;
    logic [FW-1:0]    w_fidx;
    can_entry_t       w_new;
    can_entry_t       w_head;
    logic [5:0]       w_thr_eff;
    logic [31:0]      w_stat;
    logic [31:0]      w_ctrl;

    assign w_key = can_key(frm_ext, frm_rtr, frm_id);

    can_acc_filter #(.NFILT(NFILT)) u_filter (
        .i_key    (w_key),
        .i_fen    (r_fen),
        .i_match  (r_match),
        .i_mask   (r_mask),
        .o_accept (w_accept),
        .o_fhit   (w_fhit)
    );

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_cmd_wr   = cs & we & (rs == CMD);
    assign w_flush    = w_cmd_wr & d[CMD_FLUSH];
    assign w_ovf_clr  = w_cmd_wr & d[CMD_OVFCLR];
    assign w_pop      = w_cmd_wr & d[CMD_POP] & ~w_empty;
    assign w_push_req = frm_valid & w_accept;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req & (~w_full | w_pop) & ~w_flush;
    assign w_ovf_evt  = w_push_req & w_full & ~w_pop;
    assign w_fsel_ok  = ({29'd0, r_fsel} < 32'(NFILT));
    assign w_fidx     = r_fsel[FW-1:0];

    assign w_new = '{ext: frm_ext, rtr: frm_rtr, id: frm_id, dlc: frm_dlc,
                     data: frm_data, fhit: w_fhit};
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    // Entry storage; contents are only observable through the head when non-empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a coincident overflow beats the clear command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // Control and filter register writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fen    <= '0;
            r_thresh <= 5'd1;
            r_fsel   <= 3'd0;
            r_irqen  <= 2'd0;
            r_match  <= '0;
            r_mask   <= '0;
        end else if (cs & we) begin
            case (rs)
                CTRL: begin
                    r_fen    <= d[CTRL_FEN_LSB +: NFILT];
                    r_thresh <= d[CTRL_THR_LSB +: 5];
                    r_fsel   <= d[CTRL_FSEL_LSB +: 3];
                    r_irqen  <= d[CTRL_IRQEN_LSB +: 2];
                end
                FMATCH: begin
                    if (w_fsel_ok) begin
                        r_match[w_fidx] <= d;
                    end else begin
                        r_match <= r_match;
                    end
                end
                FMASK: begin
                    if (w_fsel_ok) begin
                        r_mask[w_fidx] <= d;
                    end else begin
                        r_mask <= r_mask;
                    end
                end
                default: begin
                    r_fen <= r_fen;
                end
            endcase
        end else begin
            r_fen <= r_fen;
        end
    end

    // Threshold clamped to 1..DEPTH so irq_rx is always reachable.
    always_comb begin
        if (r_thresh == 5'd0) begin
            w_thr_eff = 6'd1;
        end else if (6'(r_thresh) > 6'(DEPTH)) begin
            w_thr_eff = 6'(DEPTH);
        end else begin
            w_thr_eff = 6'(r_thresh);
        end
    end

    // Interrupt outputs registered one cycle behind their conditions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_rx  <= 1'b0;
            r_irq_ovf <= 1'b0;
        end else begin
            r_irq_rx  <= r_irqen[0] & (6'(r_count) >= w_thr_eff);
            r_irq_ovf <= r_irqen[1] & r_ovf;
        end
    end

    assign irq_rx  = r_irq_rx;
    assign irq_ovf = r_irq_ovf;

    // Status and control read images.
    always_comb begin
        w_stat        = '0;
        w_stat[3:0]   = w_head.dlc;
        w_stat[6:4]   = w_head.fhit;
        w_stat[7]     = r_ovf;
        w_stat[12:8]  = 5'(r_count);
        w_stat[13]    = w_empty;
        w_stat[14]    = w_full;
        w_ctrl        = '0;
        w_ctrl[CTRL_FEN_LSB +: NFILT] = r_fen;
        w_ctrl[CTRL_THR_LSB +: 5]     = r_thresh;
        w_ctrl[CTRL_FSEL_LSB +: 3]    = r_fsel;
        w_ctrl[CTRL_IRQEN_LSB +: 2]   = r_irqen;
    end

    // Read mux; the bus sees zero whenever it is not selecting this block.
    always_comb begin
        q = 32'd0;
        if (cs) begin
            case (rs)
                RXID:    q = w_empty ? 32'd0 : can_key(w_head.ext, w_head.rtr, w_head.id);
                RXSTAT:  q = w_stat;
                DATA0:   q = w_head.data[31:0];
                DATA1:   q = w_head.data[63:32];
                CTRL:    q = w_ctrl;
                FMATCH:  q = w_fsel_ok ? r_match[w_fidx] : 32'd0;
                FMASK:   q = w_fsel_ok ? r_mask[w_fidx]  : 32'd0;
                default: q = 32'd0;
            endcase
        end else begin
            q = 32'd0;
        end
    end

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the receive back-end.
module tb_can_rx_filter_fifo;

    localparam int DEPTH = 4;
    localparam int NFILT = 4;

    typedef struct {
        bit        ext;
        bit        rtr;
        bit [28:0] id;
        bit [3:0]  dlc;
        bit [63:0] data;
        int        fhit;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  rs = 3'd0;
    logic [31:0] d = 32'd0;
    logic [31:0] q;
    logic        frm_valid = 1'b0;
    logic        frm_ext = 1'b0;
    logic        frm_rtr = 1'b0;
    logic [28:0] frm_id = 29'd0;
    logic [3:0]  frm_dlc = 4'd0;
    logic [63:0] frm_data = 64'd0;
    logic        irq_rx;
    logic        irq_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t      m_q[$];
    bit        m_ovf;
    bit [7:0]  m_fen;
    bit [4:0]  m_thresh;
    bit [2:0]  m_fsel;
    bit [1:0]  m_irqen;
    bit [31:0] m_match[8];
    bit [31:0] m_mask[8];

    can_rx_filter_fifo #(.DEPTH(DEPTH), .NFILT(NFILT)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs), .d(d), .q(q),
        .frm_valid(frm_valid), .frm_ext(frm_ext), .frm_rtr(frm_rtr),
        .frm_id(frm_id), .frm_dlc(frm_dlc), .frm_data(frm_data),
        .irq_rx(irq_rx), .irq_ovf(irq_ovf)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_ovf = 0; m_fen = 0; m_thresh = 5'd1; m_fsel = 0; m_irqen = 0;
        for (int i = 0; i < 8; i++) begin
            m_match[i] = 0;
            m_mask[i]  = 0;
        end
    endfunction

    function automatic int eff_thr();
        int t = m_thresh;
        if (t < 1) t = 1;
        if (t > DEPTH) t = DEPTH;
        return t;
    endfunction

    function automatic bit [31:0] exp_reg(input int r);
        ent_t h;
        bit   e = (m_q.size() == 0);
        bit [31:0] v;
        h = '{default: 0};
        if (!e) h = m_q[0];
        case (r)
            0: v = e ? 32'd0 : {h.ext, h.rtr, 1'b0, h.id};
            1: v = (e ? 32'd0 : (32'(h.dlc) + 32'(h.fhit) * 16)) + 32'(m_ovf) * 128
                   + 32'(m_q.size()) * 256 + 32'(e) * 8192 + 32'(m_q.size() == DEPTH) * 16384;
            2: v = h.data[31:0];
            3: v = h.data[63:32];
            5: v = 32'(m_fen) + 32'(m_thresh) * 256 + 32'(m_fsel) * 65536 + 32'(m_irqen) * 16777216;
            6: v = (m_fsel < NFILT) ? m_match[m_fsel] : 32'd0;
            7: v = (m_fsel < NFILT) ? m_mask[m_fsel] : 32'd0;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Apply one clock edge's worth of the behavioural rules to the model.
    function automatic void model_step();
        bit [31:0] key;
        bit acc, found, cmd, pop, flush, full, pushreq, ovf_ev;
        int fh;
        ent_t e;
        key = {frm_ext, frm_rtr, 1'b0, frm_id};
        acc = (m_fen == 0); found = 0; fh = 0;
        for (int i = 0; i < NFILT; i++) begin
            if (!found && m_fen[i] && ((key ^ m_match[i]) & m_mask[i]) == 0) begin
                found = 1; acc = 1; fh = i;
            end
        end
        cmd     = cs && we && rs == 3'd4;
        full    = (m_q.size() == DEPTH);
        pop     = cmd && d[0] && m_q.size() > 0;
        flush   = cmd && d[1];
        pushreq = frm_valid && acc;
        ovf_ev  = pushreq && full && !pop;
        e = '{ext: frm_ext, rtr: frm_rtr, id: frm_id, dlc: frm_dlc, data: frm_data, fhit: fh};
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (pushreq && !ovf_ev) m_q.push_back(e);
        end
        if (ovf_ev) m_ovf = 1;
        else if (cmd && d[2]) m_ovf = 0;
        if (cs && we && rs == 3'd5) begin
            m_fen    = d[7:0] & 8'((1 << NFILT) - 1);
            m_thresh = d[12:8];
            m_fsel   = d[18:16];
            m_irqen  = d[25:24];
        end
        if (cs && we && rs == 3'd6 && m_fsel < NFILT) m_match[m_fsel] = d;
        if (cs && we && rs == 3'd7 && m_fsel < NFILT) m_mask[m_fsel]  = d;
    endfunction

    task automatic check_regs();
        for (int r = 0; r < 8; r++) begin
            cs = 1'b1; we = 1'b0; rs = 3'(r);
            #1;
            chk($sformatf("reg%0d", r), q, exp_reg(r));
        end
        cs = 1'b0;
        #1;
        chk("q_idle", q, 32'd0);
    endtask

    task automatic tick();
        bit exp_rx, exp_ovf;
        exp_rx  = m_irqen[0] && (m_q.size() >= eff_thr());
        exp_ovf = m_irqen[1] && m_ovf;
        @(posedge clk);
        model_step();
        #1;
        cs = 1'b0; we = 1'b0; frm_valid = 1'b0;
        chk("irq_rx", 32'(irq_rx), 32'(exp_rx));
        chk("irq_ovf", 32'(irq_ovf), 32'(exp_ovf));
        check_regs();
    endtask

    task automatic set_frame(input bit ext, input bit rtr, input bit [28:0] id,
                             input bit [3:0] dlc, input bit [63:0] data);
        frm_valid = 1'b1; frm_ext = ext; frm_rtr = rtr;
        frm_id = id; frm_dlc = dlc; frm_data = data;
    endtask

    task automatic set_wr(input bit [2:0] r, input bit [31:0] v);
        cs = 1'b1; we = 1'b1; rs = r; d = v;
    endtask

    task automatic rd(input bit [2:0] r, output logic [31:0] v);
        cs = 1'b1; we = 1'b0; rs = r;
        #1;
        v = q;
        cs = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();

        // Filters off: every frame accepted.
        set_frame(0, 0, 29'h123, 4'd2, 64'hBEEF); tick();
        rd(3'd1, v); chk("plan_stat", v, 32'h0000_0102);
        rd(3'd0, v); chk("plan_rxid", v, 32'h0000_0123);
        rd(3'd2, v); chk("plan_data0", v, 32'h0000_BEEF);

        // Filter 1 on 0x12x.
        set_wr(3'd5, 32'h0001_0102); tick();
        set_wr(3'd6, 32'h0000_0120); tick();
        set_wr(3'd7, 32'hFFFF_FFF0); tick();
        set_wr(3'd4, 32'd1); tick();
        set_frame(0, 0, 29'h12A, 4'd1, 64'h55); tick();
        rd(3'd1, v); chk("plan_fhit", v, 32'h0000_0111);
        set_frame(0, 0, 29'h133, 4'd1, 64'h66); tick();
        rd(3'd1, v); chk("plan_reject", v, 32'h0000_0111);

        // Overflow on a full FIFO, then clear.
        set_wr(3'd4, 32'd2); tick();
        set_wr(3'd5, 32'h0200_0100); tick();
        for (int i = 0; i < 5; i++) begin
            set_frame(i[0], 0, 29'(i + 1), 4'(i), 64'(i * 16 + 7)); tick();
        end
        tick();
        chk("plan_irq_ovf", 32'(irq_ovf), 32'd1);
        rd(3'd0, v); chk("plan_head1", v, 32'h0000_0001);
        set_wr(3'd4, 32'd4); tick();
        set_frame(0, 1, 29'h1ABCDEF, 4'd8, 64'h0123_4567_89AB_CDEF); set_wr(3'd4, 32'd1); tick();
        rd(3'd1, v); chk("plan_popush", v & 32'h0000_7F80, 32'h0000_4400);
        for (int i = 0; i < 4; i++) begin
            set_wr(3'd4, 32'd1); tick();
        end

        // Threshold interrupt.
        set_wr(3'd4, 32'd2); tick();
        set_wr(3'd5, 32'h0100_0300); tick();
        for (int i = 0; i < 3; i++) begin
            set_frame(0, 0, 29'(16 + i), 4'd3, 64'(i)); tick();
        end
        tick();
        chk("plan_irq_rx", 32'(irq_rx), 32'd1);
        set_wr(3'd4, 32'd1); tick();
        tick();

        // Flush wins over a same-cycle push.
        set_frame(0, 0, 29'h77, 4'd1, 64'h1); set_wr(3'd4, 32'd3); tick();
        rd(3'd1, v); chk("plan_flush", v, 32'h0000_2000);

        for (int n = 0; n < 1500; n++) begin
            int r;
            if ($urandom_range(0, 1) == 1) begin
                bit [28:0] id;
                case ($urandom_range(0, 3))
                    0:       id = 29'h120 | 29'($urandom_range(0, 15));
                    1:       id = 29'h133;
                    2:       id = 29'($urandom);
                    default: id = 29'($urandom & 32'h7FF);
                endcase
                set_frame($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, id,
                          4'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            r = $urandom_range(0, 99);
            if (r < 25)      set_wr(3'd4, 32'd1);
            else if (r < 28) set_wr(3'd4, 32'($urandom_range(0, 7)));
            else if (r < 32) set_wr(3'd5, $urandom & 32'h0307_1F0F);
            else if (r < 36) set_wr(3'd6, ($urandom_range(0, 1) == 1) ? 32'h120 : $urandom);
            else if (r < 40) set_wr(3'd7, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : ($urandom & $urandom & $urandom));
            else if (r < 45) begin
                cs = 1'b1; we = 1'b0; rs = 3'($urandom_range(0, 7));
            end
            tick();
            if (n == 700) begin
                #2;
                reset = 1'b1;
                #1;
                rd(3'd1, v); chk("rst_stat", v, 32'h0000_2000);
                chk("rst_irq_rx", 32'(irq_rx), 32'd0);
                chk("rst_irq_ovf", 32'(irq_ovf), 32'd0);
                rd(3'd6, v); chk("rst_match", v, 32'd0);
                m_reset();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
